// File: rtl/game_state_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_state_fsm                                               |
// | Description : Game-flow controller (MENU / PLAY / WON / LOST). Buttons     |
// |               are synchronised and edge-detected internally. Moore state   |
// |               outputs clear the downstream level counter whenever the      |
// |               game is not in PLAY.                                         |
// | Ports       : clk        - game clock, rising edge                         |
// |               reset      - asynchronous, active-low reset                  |
// |               start_btn  - raw start button (asynchronous)                 |
// |               menu_btn   - raw menu/abort button (asynchronous)            |
// |               collision  - player/obstacle overlap (clk domain)            |
// |               game_time  - elapsed level time from the level counter       |
// |               menuScreen / playing / playerWon / playerLost - state flags  |
// |               win_count  - wins since reset, saturating at 255             |
// |               best_time  - longest game_time reached in a lost game        |
// | Options     : GAME_BEST_TIME_EN - builds the best_time register; when      |
// |               undefined best_time is tied to zero.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module game_state_fsm #(
  parameter int TW          = 11,
  parameter int WIN_TIME    = 200,
  parameter int HOLD_CYCLES = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_btn,
  input  logic          menu_btn,
  input  logic          collision,
  input  logic [TW-1:0] game_time,
  output logic          menuScreen,
  output logic          playerWon,
  output logic          playerLost,
  output logic          playing,
  output logic [7:0]    win_count,
  output logic [TW-1:0] best_time
);

  localparam int                   c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]        c_WIN_TIME  = TW'(WIN_TIME);

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_start_sync;
  logic [1:0]          r_menu_sync;
  logic                r_start_prev;
  logic                r_menu_prev;
  logic                w_start_rise;
  logic                w_menu_rise;
  logic [c_HOLD_W-1:0] r_hold;
  logic [7:0]          r_win_count;
  logic                w_screen_now;
  logic                w_screen_next;

  // Two-flop synchronisers followed by a previous-value flop for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_sync <= 2'b00;
      r_menu_sync  <= 2'b00;
      r_start_prev <= 1'b0;
      r_menu_prev  <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], start_btn};
      r_menu_sync  <= {r_menu_sync[0], menu_btn};
      r_start_prev <= r_start_sync[1];
      r_menu_prev  <= r_menu_sync[1];
    end
  end

  assign w_start_rise = r_start_sync[1] & ~r_start_prev;
  assign w_menu_rise  = r_menu_sync[1]  & ~r_menu_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_MENU;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_MENU: begin
        if (w_start_rise) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        // Collision outranks the win check, so a simultaneous hit loses.
        if (w_menu_rise)                    w_state_next = ST_MENU;
        else if (collision)                 w_state_next = ST_LOST;
        else if (game_time == c_WIN_TIME)   w_state_next = ST_WON;
      end
      ST_WON, ST_LOST: begin
        if (w_menu_rise)                    w_state_next = ST_MENU;
        else if (w_start_rise)              w_state_next = ST_PLAY;
        else if (r_hold == c_HOLD_LAST)     w_state_next = ST_MENU;
      end
      default: w_state_next = ST_MENU;
    endcase
  end

  // WON/LOST are only entered from PLAY, so zeroing the counter whenever
  // the machine is not staying on an end screen clears it on every entry.
  assign w_screen_now  = (r_state == ST_WON) || (r_state == ST_LOST);
  assign w_screen_next = (w_state_next == ST_WON) || (w_state_next == ST_LOST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
    end else if (w_screen_now && w_screen_next) begin
      r_hold <= r_hold + c_HOLD_W'(1);
    end else begin
      r_hold <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_count <= 8'd0;
    end else if ((r_state == ST_PLAY) && (w_state_next == ST_WON) && (r_win_count != 8'hFF)) begin
      r_win_count <= r_win_count + 8'd1;
    end
  end

`ifdef GAME_BEST_TIME_EN
  logic [TW-1:0] r_best_time;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_time <= '0;
    end else if ((r_state == ST_PLAY) && (w_state_next == ST_LOST) && (game_time > r_best_time)) begin
      r_best_time <= game_time;
    end
  end

  assign best_time = r_best_time;
`else
  assign best_time = '0;
`endif

  assign menuScreen = (r_state == ST_MENU);
  assign playing    = (r_state == ST_PLAY);
  assign playerWon  = (r_state == ST_WON);
  assign playerLost = (r_state == ST_LOST);
  assign win_count  = r_win_count;

endmodule
`default_nettype wire

// File: tb/tb_game_state_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_game_state_fsm                                            |
// | Description : Randomised self-checking bench for game_state_fsm against a  |
// |               behavioural model of the game flow. The bench also plays     |
// |               the level counter, driving game_time from the model state.   |
// | Options     : GAME_BEST_TIME_EN - enables best_time modelling.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_game_state_fsm;

  localparam int TW          = 8;
  localparam int WIN_TIME    = 24;
  localparam int HOLD_CYCLES = 12;

  localparam int M_MENU = 0;
  localparam int M_PLAY = 1;
  localparam int M_WON  = 2;
  localparam int M_LOST = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_btn = 1'b0;
  logic          menu_btn = 1'b0;
  logic          collision = 1'b0;
  logic [TW-1:0] game_time = '0;
  logic          menuScreen;
  logic          playerWon;
  logic          playerLost;
  logic          playing;
  logic [7:0]    win_count;
  logic [TW-1:0] best_time;

  game_state_fsm #(
    .TW          (TW),
    .WIN_TIME    (WIN_TIME),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .menu_btn   (menu_btn),
    .collision  (collision),
    .game_time  (game_time),
    .menuScreen (menuScreen),
    .playerWon  (playerWon),
    .playerLost (playerLost),
    .playing    (playing),
    .win_count  (win_count),
    .best_time  (best_time)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game state, edge count, entry edge of the current end
  // screen, the level-counter value, and the raw button samples seen at the
  // last three edges (index 0 = most recent).
  int m_state;
  int m_wins;
  int m_best;
  int m_entry;
  int m_cyc;
  int m_gt;
  int hist_s[3];
  int hist_m[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_MENU;
    m_wins  = 0;
    m_best  = 0;
    m_entry = 0;
    m_cyc   = 0;
    m_gt    = 0;
    for (int i = 0; i < 3; i++) begin
      hist_s[i] = 0;
      hist_m[i] = 0;
    end
  endtask

  // One rising edge of the game clock, using the inputs currently applied.
  task automatic model_edge();
    int s_rise;
    int m_rise;
    int nxt;
    // A press sampled two edges ago that was absent three edges ago acts now.
    s_rise = (hist_s[1] == 1 && hist_s[2] == 0) ? 1 : 0;
    m_rise = (hist_m[1] == 1 && hist_m[2] == 0) ? 1 : 0;
    nxt = m_state;
    if (m_state == M_MENU) begin
      if (s_rise != 0) nxt = M_PLAY;
    end else if (m_state == M_PLAY) begin
      if (m_rise != 0)                       nxt = M_MENU;
      else if (collision)                    nxt = M_LOST;
      else if (int'(game_time) == WIN_TIME)  nxt = M_WON;
    end else begin
      if (m_rise != 0)                          nxt = M_MENU;
      else if (s_rise != 0)                     nxt = M_PLAY;
      else if (m_cyc - m_entry == HOLD_CYCLES)  nxt = M_MENU;
    end
    if (m_state == M_PLAY && nxt == M_WON && m_wins < 255) m_wins++;
`ifdef GAME_BEST_TIME_EN
    if (m_state == M_PLAY && nxt == M_LOST && int'(game_time) > m_best) m_best = int'(game_time);
`endif
    if (m_state == M_PLAY && (nxt == M_WON || nxt == M_LOST)) m_entry = m_cyc;
    m_gt = (nxt == M_PLAY && m_state == M_PLAY) ? m_gt + 1 : 0;
    m_state = nxt;
    hist_s[2] = hist_s[1]; hist_s[1] = hist_s[0]; hist_s[0] = int'(start_btn);
    hist_m[2] = hist_m[1]; hist_m[1] = hist_m[0]; hist_m[0] = int'(menu_btn);
    m_cyc++;
  endtask

  task automatic check_outputs();
    check_eq("menuScreen", 32'(menuScreen), 32'(m_state == M_MENU));
    check_eq("playing",    32'(playing),    32'(m_state == M_PLAY));
    check_eq("playerWon",  32'(playerWon),  32'(m_state == M_WON));
    check_eq("playerLost", 32'(playerLost), 32'(m_state == M_LOST));
    check_eq("win_count",  32'(win_count),  32'(m_wins));
    check_eq("best_time",  32'(best_time),  32'(m_best));
  endtask

  // ps/pm: 1-in-N chance per cycle of toggling start/menu (0 = keep low).
  // pc: 1-in-N chance of collision (0 = never); cw: 50% collision at the win time.
  task automatic step(input int ps, input int pm, input int pc, input bit cw);
    @(negedge clk);
    check_outputs();
    if (ps == 0) start_btn = 1'b0;
    else if ($urandom_range(ps - 1) == 0) start_btn = ~start_btn;
    if (pm == 0) menu_btn = 1'b0;
    else if ($urandom_range(pm - 1) == 0) menu_btn = ~menu_btn;
    collision = (pc != 0) && ($urandom_range(pc - 1) == 0);
    if (cw && m_gt == WIN_TIME) collision = ($urandom_range(1) == 1);
    game_time = TW'(m_gt);
    @(posedge clk);
    model_edge();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_menu"}, 32'(menuScreen), 32'd1);
    check_eq({tag, "_play"}, 32'(playing),    32'd0);
    check_eq({tag, "_won"},  32'(playerWon),  32'd0);
    check_eq({tag, "_lost"}, 32'(playerLost), 32'd0);
    check_eq({tag, "_wins"}, 32'(win_count),  32'd0);
    check_eq({tag, "_best"}, 32'(best_time),  32'd0);
  endtask

  initial begin
    int guard;
    model_reset();
    #1;
    check_reset_values("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_edge();

    // Idle after reset: must sit in MENU.
    repeat (50) step(0, 0, 0, 1'b0);

    // General random play.
    repeat (3000) step(8, 40, 30, 1'b0);

    // Stress collision exactly at the win time.
    repeat (1500) step(8, 0, 60, 1'b1);

    // Collect at least five wins, then abort with reset while in PLAY.
    guard = 0;
    while (!(m_wins >= 5 && m_state == M_PLAY && m_gt > 3) && guard < 5000) begin
      step(4, 0, 0, 1'b0);
      guard++;
    end
    check_eq("reach_midplay", 32'(guard < 5000), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    start_btn = 1'b0;
    menu_btn = 1'b0;
    collision = 1'b0;
    model_reset();
    game_time = '0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    check_reset_values("held_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_edge();

    // Win repeatedly until the counter saturates, then keep winning.
    guard = 0;
    while (m_wins < 255 && guard < 30000) begin
      step(4, 0, 0, 1'b0);
      guard++;
    end
    repeat (500) step(4, 0, 0, 1'b0);
    @(negedge clk);
    check_eq("wins_saturate", 32'(win_count), 32'd255);

    // Mixed random play again, including aborts and losses.
    repeat (1500) step(6, 30, 25, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
